// File: rtl/darkdebug_tap_if.sv
// Debug-trace bundle between the darkdpgroup debug lanes and the trace tap:
// captured lanes and enable going in, serial trace and status coming back.
interface darkdebug_tap_if;
    logic [3:0][31:0] DEBUG;
    logic             EN;
    logic             UART_TXD;
    logic             BUSY;
    logic             OVF;
    logic [7:0]       DROPS;

    modport master (
        output DEBUG, EN,
        input  UART_TXD, BUSY, OVF, DROPS
    );

    modport slave (
        input  DEBUG, EN,
        output UART_TXD, BUSY, OVF, DROPS
    );
endinterface

// File: rtl/darkdebug_tap.sv
// Debug-lane change tracer: records {lane, value} on each lane change and
// streams every record as a 6-byte 8N1 UART frame (A5, lane, data MSB first).
module darkdebug_tap #(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 868
) (
    input  logic           XCLK,
    input  logic           XRES,
    darkdebug_tap_if.slave dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [3:0][31:0] shadow_q;
    logic [3:0][31:0] pval_q;
    logic [3:0]       pend_q;
    logic [3:0]       chg;
    logic [3:0]       pushed;
    logic [3:0]       drop;
    logic [1:0]       sel;
    logic             push;
    logic [2:0]       drop_cnt;

    logic [33:0]      mem [FIFO_DEPTH];
    logic [AW:0]      wptr_q, rptr_q, wptr_n, rptr_n;
    logic             empty, full;
    logic [33:0]      rd_data;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [33:0]      frame_q;
    logic             pop;
    logic             baud_end;
    logic [7:0]       cur_byte;

    logic             txd_q;
    logic             busy_q;
    logic             ovf_q;
    logic [7:0]       drops_q;

    // Change detection and lowest-lane-first arbitration
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            chg[i] = dbg.EN && (dbg.DEBUG[i] != shadow_q[i]);
            if (pend_q[i]) sel = 2'(i);
        end
        push     = (|pend_q) && !full;
        pushed   = push ? (4'b0001 << sel) : 4'b0000;
        drop     = chg & pend_q & ~pushed;
        drop_cnt = 3'($countones(drop));
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            shadow_q <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            drops_q  <= 8'd0;
        end else begin
            shadow_q <= dbg.DEBUG;
            for (int i = 0; i < 4; i++) begin
                if (chg[i])         pend_q[i] <= 1'b1;
                else if (pushed[i]) pend_q[i] <= 1'b0;
            end
            if (|drop) begin
                ovf_q   <= 1'b1;
                drops_q <= sat_add8(drops_q, drop_cnt);
            end
        end
    end

    // A change on the lane being pushed replaces the value without loss
    always_ff @(posedge XCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (chg[i]) pval_q[i] <= dbg.DEBUG[i];
        end
    end

    // Record FIFO: the extra pointer bit separates full from empty
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data = mem[rptr_q[AW-1:0]];
    assign wptr_n  = wptr_q + {{AW{1'b0}}, push};
    assign rptr_n  = rptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge XCLK) begin
        if (push) mem[wptr_q[AW-1:0]] <= {sel, pval_q[sel]};
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_n;
            rptr_q <= rptr_n;
        end
    end

    // Serializer
    assign baud_end = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = {6'b0, frame_q[33:32]};
            3'd2:    cur_byte = frame_q[31:24];
            3'd3:    cur_byte = frame_q[23:16];
            3'd4:    cur_byte = frame_q[15:8];
            3'd5:    cur_byte = frame_q[7:0];
            default: cur_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = 3'd0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (byte_q != 3'd5) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                    end else if (!empty) begin
                        // Chain straight into the next frame without an idle bit
                        pop     = 1'b1;
                        byte_d  = 3'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txd_q   <= (state_q == S_START) ? 1'b0 :
                       (state_q == S_DATA)  ? cur_byte[bit_q] : 1'b1;
            busy_q  <= (wptr_n != rptr_n) || (state_d != S_IDLE);
        end
    end

    always_ff @(posedge XCLK) begin
        if (pop) frame_q <= rd_data;
    end

    assign dbg.UART_TXD = txd_q;
    assign dbg.BUSY     = busy_q;
    assign dbg.OVF      = ovf_q;
    assign dbg.DROPS    = drops_q;

endmodule
